// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Bit timing comes from an external baud_tick strobe at OVERSAMPLE x baud.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ready,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || OVERSAMPLE < 2 || OVERSAMPLE > 64) begin : g_bad_param
    $fatal(1, "uart_tx_frame: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  assign bit_end = baud_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Ticks in the accept cycle are not counted: tick_q is cleared while idle.
    if (state_q != S_IDLE && baud_tick) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tick_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (start) begin
          shift_d = data;
          par_d   = (^data) ^ ODD;
          state_d = S_START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7N2) sharing
// clock, reset and a baud_tick every 4 clk, so one bit period is 64 clk.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] sel = 2'd0;
  logic [1:0] div = 2'd0;
  logic [3:0] start_v, tx_v, ready_v, busy_v, done_v;
  logic       tx_s, ready_s, busy_s, done_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign baud_tick = (div == 2'd3);

  assign start_v = start ? (4'b0001 << sel) : 4'b0000;
  assign tx_s    = tx_v[sel];
  assign ready_s = ready_v[sel];
  assign busy_s  = busy_v[sel];
  assign done_s  = done_v[sel];

  uart_tx_frame u_8n1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start_v[0]), .data(data),
    .tx(tx_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_frame #(.PARITY(1)) u_8e1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start_v[1]), .data(data),
    .tx(tx_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_frame #(.PARITY(2)) u_8o1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start_v[2]), .data(data),
    .tx(tx_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start_v[3]), .data(data[6:0]),
    .tx(tx_v[3]), .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // pat holds the frame in transmission order, first bit at index nbits-1.
  typedef struct {
    logic [1:0]  dut;
    logic [7:0]  d;
    int          nbits;
    logic [11:0] pat;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] d_sel, input logic [7:0] d, input int nbits,
                      input logic [11:0] pat, input string nm, input bit keep_start,
                      input logic [7:0] next_d, input bit mid_start);
    int  cnt;
    int  k;
    bit  ready_hi;
    bit  got_done;
    sel   = d_sel;
    data  = d;
    start = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_acc_tx"}, tx_s, 0);
    chk({nm, "_acc_busy"}, busy_s, 1);
    chk({nm, "_acc_ready"}, ready_s, 0);
    if (!keep_start) start = 1'b0;
    ready_hi = 1'b0;
    got_done = 1'b0;
    k = 0;
    for (cnt = 1; cnt <= nbits * 64 + 40; cnt++) begin
      @(posedge clk); #1;
      if (mid_start && cnt == 200) begin
        data  = 8'hFF;
        start = 1'b1;
      end
      if (mid_start && cnt == 201) start = 1'b0;
      if (k < nbits && cnt == 32 + 64 * k) begin
        chk($sformatf("%s_bit%0d", nm, k), tx_s, pat[nbits-1-k]);
        k++;
      end
      if (done_s) begin
        got_done = 1'b1;
        break;
      end
      if (ready_s) ready_hi = 1'b1;
    end
    checks++;
    if (!got_done || cnt < nbits * 64 - 4 || cnt > nbits * 64 + 4) begin
      errors++;
      $display("FAIL %s_len got %0d clk (done seen %0d) want %0d +-4", nm, cnt, got_done, nbits * 64);
    end
    chk({nm, "_ready_low"}, ready_hi, 0);
    chk({nm, "_done_ready"}, ready_s, 1);
    chk({nm, "_done_busy"}, busy_s, 0);
    chk({nm, "_done_tx"}, tx_s, 1);
    if (keep_start) begin
      data = next_d;
    end else begin
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, done_s, 0);
      chk({nm, "_idle_busy"}, busy_s, 0);
    end
    $display("frame %s dut=%0d data=%h bits=%0d len=%0d clk", nm, d_sel, d, nbits, cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 8'hA5, 10, 12'b0101001011,  "8n1_a5"};
    vecs[1] = '{2'd0, 8'hFF, 10, 12'b0111111111,  "8n1_ff"};
    vecs[2] = '{2'd1, 8'hA5, 11, 12'b01010010101, "8e1_a5"};
    vecs[3] = '{2'd1, 8'h01, 11, 12'b01000000011, "8e1_01"};
    vecs[4] = '{2'd2, 8'hA5, 11, 12'b01010010111, "8o1_a5"};
    vecs[5] = '{2'd2, 8'h00, 11, 12'b00000000011, "8o1_00"};
    vecs[6] = '{2'd3, 8'h41, 10, 12'b0100000111,  "7n2_41"};
    vecs[7] = '{2'd3, 8'h7F, 10, 12'b0111111111,  "7n2_7f"};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      chk($sformatf("rst%0d_tx", i), tx_s, 1);
      chk($sformatf("rst%0d_ready", i), ready_s, 1);
      chk($sformatf("rst%0d_busy", i), busy_s, 0);
      chk($sformatf("rst%0d_done", i), done_s, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].dut, vecs[i].d, vecs[i].nbits, vecs[i].pat, vecs[i].name, 1'b0, 8'h00, 1'b0);
      repeat (7) @(posedge clk);
      #1;
    end

    // start with 0xFF during a 0x3C frame must be ignored
    send(2'd0, 8'h3C, 10, 12'b0001111001, "ign_3c", 1'b0, 8'h00, 1'b1);
    repeat (5) @(posedge clk);
    #1;

    // start held high: 0x55 then 0xAA back-to-back
    send(2'd0, 8'h55, 10, 12'b0101010101, "b2b_55", 1'b1, 8'hAA, 1'b0);
    send(2'd0, 8'hAA, 10, 12'b0010101011, "b2b_aa", 1'b0, 8'h00, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // asynchronous reset while a data bit of value 0 is on the line
    sel   = 2'd0;
    data  = 8'h3C;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("pre_rst_tx", tx_s, 0);
    chk("pre_rst_busy", busy_s, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_tx", tx_s, 1);
    chk("async_rst_ready", ready_s, 1);
    chk("async_rst_busy", busy_s, 0);
    chk("async_rst_done", done_s, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("post_rst_tx", tx_s, 1);
    chk("post_rst_ready", ready_s, 1);
    chk("post_rst_busy", busy_s, 0);
    $display("reset mid-frame aborted, line idle after release");
    send(2'd0, 8'h12, 10, 12'b0010010001, "post_rst_12", 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
